// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   uart_state_t : frame FSM state encoding (IDLE/START/DATA/STOP)
//   DATA_W       : payload width
//   FRAME_W      : start + data + parity + stop
//   START_BIT    : line level of the start bit
//   STOP_BIT     : line level of the stop bit (and of the idle line)
package uart_pkg;

  localparam int   DATA_W    = 8;
  localparam int   FRAME_W   = 11;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_t;

  // Frame image in line order: bit 0 goes out first.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [DATA_W-1:0] data,
                                                     input logic              odd);
    return {STOP_BIT, (^data) ^ odd, data, START_BIT};
  endfunction

endpackage

// File: rtl/uart_tx_piso.sv
// uart_tx_piso: 11-bit parallel-in/serial-out frame register.
//   baud_clk : clock
//   rst      : asynchronous active-high reset (register fills with ones)
//   load     : capture frame (wins over shift)
//   shift    : shift right one bit, filling with the stop level
//   frame    : parallel frame image, bit 0 first on the line
//   ser_out  : serial line, taken straight from the register LSB
module uart_tx_piso
  import uart_pkg::*;
(
  input  logic               baud_clk,
  input  logic               rst,
  input  logic               load,
  input  logic               shift,
  input  logic [FRAME_W-1:0] frame,
  output logic               ser_out
);

  logic [FRAME_W-1:0] shreg_q, shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = frame;
    end else if (shift) begin
      // Filling with ones leaves the line high once the stop bit has gone out.
      shreg_d = {STOP_BIT, shreg_q[FRAME_W-1:1]};
    end
  end

  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '1;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign ser_out = shreg_q[0];

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART serial transmitter with a one-word holding buffer.
//   baud_clk      : clock
//   rst           : asynchronous active-high reset
//   tx_data       : word to send, captured when tx_valid && tx_ready
//   tx_valid      : tx_data is valid
//   tx_ready      : holding buffer empty
//   data_tx       : serial line, idles high
//   current_state : FSM state
//   shift         : pulse on the last cycle of each bit period
//   busy          : a frame is on the line
//
// state | meaning
// IDLE  | line high, waiting for a held word
// START | start bit on the line (bit 0)
// DATA  | data bits d0..d7 then parity (bits 1..9)
// STOP  | stop bit (bit 10); reloads directly if a word is held
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic              baud_clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              data_tx,
  output logic [1:0]        current_state,
  output logic              shift,
  output logic              busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_TC = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_t       state_q, state_d;
  logic [CNT_W-1:0]  baud_cnt_q, baud_cnt_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic              load;
  logic              bit_end;

  assign bit_end = (state_q != IDLE) && (baud_cnt_q == BAUD_TC);

  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    load        = 1'b0;

    // Accept needs an empty buffer and load needs a full one, so they never coincide.
    if (tx_valid && !hold_full_q) begin
      hold_full_d = 1'b1;
      hold_data_d = tx_data;
    end

    if (bit_end) begin
      baud_cnt_d = '0;
      bit_cnt_d  = bit_cnt_q + 4'd1;
    end else if (state_q != IDLE) begin
      baud_cnt_d = baud_cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (hold_full_q) load = 1'b1;
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end && (bit_cnt_q == 4'd9)) state_d = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (hold_full_q) load = 1'b1;
          else             state_d = IDLE;
          bit_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      hold_full_d = 1'b0;
      baud_cnt_d  = '0;
      bit_cnt_d   = '0;
      state_d     = START;
    end
  end

  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
    end
  end

  uart_tx_piso u_piso (
    .baud_clk (baud_clk),
    .rst      (rst),
    .load     (load),
    .shift    (bit_end),
    .frame    (build_frame(hold_data_q, PARITY_ODD)),
    .ser_out  (data_tx)
  );

  assign tx_ready      = !hold_full_q;
  assign current_state = state_q;
  assign shift         = bit_end;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx.
// dut_a: CLKS_PER_BIT=4, even parity. dut_b: CLKS_PER_BIT=1, odd parity.
// Inputs are driven and outputs sampled on the falling edge.
module tb_uart_tx;

  logic       baud_clk = 1'b0;
  logic       rst      = 1'b1;

  logic [7:0] tx_data_a  = 8'h00;
  logic       tx_valid_a = 1'b0;
  logic       tx_ready_a, data_tx_a, shift_a, busy_a;
  logic [1:0] state_a;

  logic [7:0] tx_data_b  = 8'h00;
  logic       tx_valid_b = 1'b0;
  logic       tx_ready_b, data_tx_b, shift_b, busy_b;
  logic [1:0] state_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 baud_clk = ~baud_clk;

  uart_tx #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b0)) dut_a (
    .baud_clk      (baud_clk),
    .rst           (rst),
    .tx_data       (tx_data_a),
    .tx_valid      (tx_valid_a),
    .tx_ready      (tx_ready_a),
    .data_tx       (data_tx_a),
    .current_state (state_a),
    .shift         (shift_a),
    .busy          (busy_a)
  );

  uart_tx #(.CLKS_PER_BIT(1), .PARITY_ODD(1'b1)) dut_b (
    .baud_clk      (baud_clk),
    .rst           (rst),
    .tx_data       (tx_data_b),
    .tx_valid      (tx_valid_b),
    .tx_ready      (tx_ready_b),
    .data_tx       (data_tx_b),
    .current_state (state_b),
    .shift         (shift_b),
    .busy          (busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int dut, input logic v, input logic [7:0] d);
    if (dut == 0) begin
      tx_valid_a = v;
      tx_data_a  = d;
    end else begin
      tx_valid_b = v;
      tx_data_b  = d;
    end
  endtask

  // Offer a word to an idle DUT; returns at the first cycle of its start bit.
  task automatic send(input int dut, input logic [7:0] d, input logic keep, input logic [7:0] next_d);
    drive(dut, 1'b1, d);
    @(negedge baud_clk);
    check($sformatf("dut%0d accept ready", dut), 32'(dut == 0 ? tx_ready_a : tx_ready_b), 32'd0);
    check($sformatf("dut%0d line before load", dut), 32'(dut == 0 ? data_tx_a : data_tx_b), 32'd1);
    check($sformatf("dut%0d busy before load", dut), 32'(dut == 0 ? busy_a : busy_b), 32'd0);
    drive(dut, keep, next_d);
    @(negedge baud_clk);
  endtask

  // Check one whole frame cycle by cycle, starting on its first cycle.
  // After sampling cycle evt_at the inputs are changed to evt_valid/evt_data.
  task automatic run_frame(input int dut, input string tag, input logic [10:0] exp,
                           input int evt_at, input logic evt_valid, input logic [7:0] evt_data,
                           output logic rdy_last);
    int   cpb;
    int   shifts;
    logic line, sh, rdy;
    logic [1:0] st;
    cpb    = (dut == 0) ? 4 : 1;
    shifts = 0;
    rdy_last = 1'bx;
    for (int i = 0; i < 11 * cpb; i++) begin
      line = (dut == 0) ? data_tx_a  : data_tx_b;
      sh   = (dut == 0) ? shift_a    : shift_b;
      rdy  = (dut == 0) ? tx_ready_a : tx_ready_b;
      st   = (dut == 0) ? state_a    : state_b;
      check($sformatf("%s bit%0d cyc%0d", tag, i / cpb, i % cpb), 32'(line), 32'(exp[i / cpb]));
      if (sh) shifts++;
      if (i == 0) begin
        check($sformatf("%s ready after load", tag), 32'(rdy), 32'd1);
        check($sformatf("%s state START", tag), 32'(st), 32'd1);
      end
      if (i == cpb)        check($sformatf("%s state DATA", tag), 32'(st), 32'd2);
      if (i == 10 * cpb)   check($sformatf("%s state STOP", tag), 32'(st), 32'd3);
      if (i == 11 * cpb - 1) rdy_last = rdy;
      if (i == evt_at) drive(dut, evt_valid, evt_data);
      @(negedge baud_clk);
    end
    check($sformatf("%s shift count", tag), 32'(shifts), 32'd11);
  endtask

  initial begin
    logic rdy;
    logic bad;

    // Reset state
    @(negedge baud_clk);
    check("reset line", 32'(data_tx_a), 32'd1);
    check("reset ready", 32'(tx_ready_a), 32'd1);
    check("reset busy", 32'(busy_a), 32'd0);
    check("reset shift", 32'(shift_a), 32'd0);
    check("reset state", 32'(state_a), 32'd0);
    @(negedge baud_clk);
    rst = 1'b0;

    // Idle: nothing offered for 100 cycles
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge baud_clk);
      if (data_tx_a !== 1'b1 || busy_a !== 1'b0 || shift_a !== 1'b0 ||
          data_tx_b !== 1'b1 || busy_b !== 1'b0 || shift_b !== 1'b0) bad = 1'b1;
    end
    check("idle quiet", 32'(bad), 32'd0);

    // Single frame A5, even parity (popcount 4 -> 0)
    send(0, 8'hA5, 1'b0, 8'h00);
    run_frame(0, "a5", {1'b1, 1'b0, 8'hA5, 1'b0}, -1, 1'b0, 8'h00, rdy);
    check("a5 idle after", 32'(busy_a), 32'd0);
    check("a5 line after", 32'(data_tx_a), 32'd1);

    // Odd parity with one clock per bit: shift high every frame cycle
    send(1, 8'h01, 1'b0, 8'h00);
    run_frame(1, "odd01", {1'b1, 1'b0, 8'h01, 1'b0}, -1, 1'b0, 8'h00, rdy);
    send(1, 8'h00, 1'b0, 8'h00);
    run_frame(1, "odd00", {1'b1, 1'b1, 8'h00, 1'b0}, -1, 1'b0, 8'h00, rdy);
    check("odd idle after", 32'(busy_b), 32'd0);

    // Back-to-back 00 then FF with tx_valid held
    send(0, 8'h00, 1'b1, 8'hFF);
    run_frame(0, "b2b1", {1'b1, 1'b0, 8'h00, 1'b0}, 1, 1'b0, 8'h00, rdy);
    check("b2b ready low before reload", 32'(rdy), 32'd0);
    run_frame(0, "b2b2", {1'b1, 1'b0, 8'hFF, 1'b0}, -1, 1'b0, 8'h00, rdy);
    check("b2b idle after", 32'(busy_a), 32'd0);

    // Backpressure: 11, 23, 37 offered while frame 1 is in flight
    send(0, 8'h11, 1'b1, 8'h23);
    run_frame(0, "bp1", {1'b1, 1'b0, 8'h11, 1'b0}, 1, 1'b1, 8'h37, rdy);
    check("bp1 ready at end", 32'(rdy), 32'd0);
    run_frame(0, "bp2", {1'b1, 1'b1, 8'h23, 1'b0}, 1, 1'b0, 8'h00, rdy);
    check("bp2 ready at end", 32'(rdy), 32'd0);
    run_frame(0, "bp3", {1'b1, 1'b1, 8'h37, 1'b0}, -1, 1'b0, 8'h00, rdy);
    check("bp3 ready at end", 32'(rdy), 32'd1);
    check("bp idle state", 32'(state_a), 32'd0);
    check("bp idle line", 32'(data_tx_a), 32'd1);

    // Reset at bit 5 of a frame (4A: d4=0, line low) with C3 held
    send(0, 8'h4A, 1'b1, 8'hC3);
    for (int i = 0; i < 20; i++) begin
      if (i == 1) drive(0, 1'b0, 8'h00);
      if (i == 19) check("rst word held", 32'(tx_ready_a), 32'd0);
      @(negedge baud_clk);
    end
    check("rst bit5 line low", 32'(data_tx_a), 32'd0);
    rst = 1'b1;
    #1;
    check("rst line", 32'(data_tx_a), 32'd1);
    check("rst ready", 32'(tx_ready_a), 32'd1);
    check("rst busy", 32'(busy_a), 32'd0);
    check("rst shift", 32'(shift_a), 32'd0);
    check("rst state", 32'(state_a), 32'd0);
    @(negedge baud_clk);
    @(negedge baud_clk);
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge baud_clk);
      if (data_tx_a !== 1'b1 || busy_a !== 1'b0 || shift_a !== 1'b0) bad = 1'b1;
    end
    check("no frame after rst", 32'(bad), 32'd0);
    send(0, 8'h3C, 1'b0, 8'h00);
    run_frame(0, "post_rst", {1'b1, 1'b0, 8'h3C, 1'b0}, -1, 1'b0, 8'h00, rdy);
    check("post_rst idle", 32'(busy_a), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
